ram_arbiter: RTL and testbench

- Shares the single-port 4096x16 program/data RAM between two requesters.
- Master 0 is the CPU core memory port. Master 1 is the host loader/debug port, which preloads programs and inspects memory.
- Fair round-robin arbitration; one access in flight at a time; registered request capture; read data returned in a register.
- Sits between both masters and the ram instance and owns all of its control pins.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_arb_select.sv | 39 +++
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the program/data RAM arbiter: FSM state
//   encodings and master (owner) identifiers.
package ram_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ACC  = 1'b1
  } arb_state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_arb_select.sv
// arb_select
//   Combinational winner pick between the two RAM masters.
//   Ports:
//     req0, req1  - request lines of master 0 / master 1
//     last_owner  - owner id of the most recently completed access
//     vld         - at least one request present
//     winner      - owner id of the selected master (meaningful when vld=1)
//   Configuration macro RAM_ARB_FIXED_PRIO_EN:
//     defined     - master 0 always wins a simultaneous request
//     not defined - round-robin, the master that did not go last wins
module arb_select
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic vld,
  output logic winner
);

  assign vld = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // With no request the winner is a don't-care; last_owner fills that slot.
  always_comb begin
    winner = last_owner;
    if (req0)      winner = OWN_M0;
    else if (req1) winner = OWN_M1;
  end
`else
  always_comb begin
    winner = last_owner;
    if (req0 && req1) winner = ~last_owner;
    else if (req0)    winner = OWN_M0;
    else if (req1)    winner = OWN_M1;
  end
`endif

endmodule : arb_select

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port 2**AW x DW program/data RAM between the CPU
//   memory port (master 0) and the host loader/debug port (master 1).
//   One access in flight at a time: a request is captured in IDLE, the RAM
//   is driven for one cycle in ACC, and the ack/read data follow.
//   Ports:
//     clk, reset              - clock, asynchronous active-low reset
//     m{0,1}_req/we/addr/wdata - master request side
//     m{0,1}_gnt              - one-cycle pulse: request captured
//     m{0,1}_ack              - one-cycle pulse: access complete
//     m{0,1}_rdata            - read data, held until that master's next read
//     ram_load/ram_addr/ram_d - RAM control, driven only in ACC
//     ram_q                   - RAM read data (combinational from ram_addr)
//     busy                    - access in flight
//   Configuration macro RAM_ARB_FIXED_PRIO_EN selects fixed priority
//   (master 0 wins) instead of round-robin inside arb_select.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_load,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  arb_state_e    state_q, state_d;
  logic          last_owner_q;
  logic          sel_vld, sel_win;

  logic          we_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;
  logic          owner_p0;

  arb_select u_sel (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner_q),
    .vld        (sel_vld),
    .winner     (sel_win)
  );

  logic capture;
  assign capture = (state_q == ARB_IDLE) && sel_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // RAM pins are driven only while the access is in flight so that the RAM
  // sees a clean, single-cycle strobe and reset drops it immediately.
  always_comb begin
    state_d  = state_q;
    ram_load = 1'b0;
    ram_addr = '0;
    ram_d    = '0;
    busy     = 1'b0;
    case (state_q)
      ARB_IDLE: if (sel_vld) state_d = ARB_ACC;
      ARB_ACC: begin
        state_d  = ARB_IDLE;
        ram_load = we_p0;
        ram_addr = addr_p0;
        ram_d    = wdata_p0;
        busy     = 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Stage p0: capture the winning request and pulse its grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      owner_p0 <= OWN_M0;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
    end else begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      if (capture) begin
        owner_p0 <= sel_win;
        if (sel_win == OWN_M0) begin
          we_p0    <= m0_we;
          addr_p0  <= m0_addr;
          wdata_p0 <= m0_wdata;
          m0_gnt   <= 1'b1;
        end else begin
          we_p0    <= m1_we;
          addr_p0  <= m1_addr;
          wdata_p0 <= m1_wdata;
          m1_gnt   <= 1'b1;
        end
      end
    end
  end

  // Stage p1: complete the access, return read data and pulse the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q <= OWN_M1;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      if (state_q == ARB_ACC) begin
        last_owner_q <= owner_p0;
        if (owner_p0 == OWN_M0) begin
          m0_ack <= 1'b1;
          if (!we_p0) m0_rdata <= ram_q;
        end else begin
          m1_ack <= 1'b1;
          if (!we_p0) m1_rdata <= ram_q;
        end
      end
    end
  end

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed testbench for ram_arbiter with a behavioural 4096x16 RAM.
//   Expectations follow the RAM_ARB_FIXED_PRIO_EN setting of the build.
module tb_ram_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_load, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_q;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural RAM with a bench-side preload path.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (ram_load)   mem[ram_addr] <= ram_d;
    else if (pl_en) mem[pl_addr]  <= pl_data;
  end
  assign ram_q = mem[ram_addr];

  always #5 clk = ~clk;

  ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .ram_load (ram_load),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .ram_q    (ram_q),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},  {30'd0, m1_gnt, m0_gnt}, 32'd0);
    check({tag, "_ack"},  {30'd0, m1_ack, m0_ack}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ram"},  {3'd0, ram_load, ram_addr, ram_d}, 32'd0);
  endtask

  initial begin
    logic exp_w;
    reset   = 1'b0;
    m0_req  = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req  = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // Preload RAM while held in reset.
    preload(12'h001, 16'h1111);
    preload(12'h002, 16'h2222);
    preload(12'h010, 16'h0000);
    preload(12'h020, 16'h0000);

    // Reset state
    check_quiet("rst");
    check("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);

    // Release with no request: stays idle
    reset = 1'b1;
    tick(); tick(); tick();
    check_quiet("idle");

    // m1 writes BEEF to 010
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h010; m1_wdata = 16'hBEEF;
    tick();
    check("wr_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    check("wr_busy", {31'd0, busy}, 32'd1);
    check("wr_ram", {3'd0, ram_load, ram_addr, ram_d}, {3'd0, 1'b1, 12'h010, 16'hBEEF});
    m1_req = 1'b0; m1_we = 1'b0;
    tick();
    check("wr_m1_ack", {30'd0, m1_ack, m0_ack}, 32'd2);
    check("wr_load_off", {31'd0, ram_load}, 32'd0);
    check("wr_m1_rdata", {16'd0, m1_rdata}, 32'd0);

    // m0 reads 010 -> BEEF
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h010;
    tick();
    check("rd_m0_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    check("rd_load", {31'd0, ram_load}, 32'd0);
    m0_req = 1'b0;
    tick();
    check("rd_m0_ack", {30'd0, m1_ack, m0_ack}, 32'd1);
    check("rd_m0_rdata", {16'd0, m0_rdata}, 32'h0000BEEF);

    // Both masters request continuously from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h001;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h002;
    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_w = 1'b0;
`else
      exp_w = i[0];
`endif
      tick();
      check($sformatf("both_gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, exp_w ? 32'd2 : 32'd1);
      tick();
      check($sformatf("both_ack%0d", i), {30'd0, m1_ack, m0_ack}, exp_w ? 32'd2 : 32'd1);
      if (exp_w) check($sformatf("both_rd%0d", i), {16'd0, m1_rdata}, 32'h00002222);
      else       check($sformatf("both_rd%0d", i), {16'd0, m0_rdata}, 32'h00001111);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    check_quiet("both_drain");

    // Reset during ACC of m0 write 1234 to 020
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h020; m0_wdata = 16'h1234;
    tick();
    check("abort_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    check("abort_load_on", {31'd0, ram_load}, 32'd1);
    m0_req = 1'b0; m0_we = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("abort_load_off", {31'd0, ram_load}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    check("abort_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    reset = 1'b1;
    tick();
    m0_req = 1'b1; m0_addr = 12'h020;
    tick();
    check("reread_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    tick();
    check("reread_ack", {30'd0, m1_ack, m0_ack}, 32'd1);
    check("reread_data", {31'd0, (m0_rdata == 16'h0000) || (m0_rdata == 16'h1234)}, 32'd1);

    // m0 holds req through ack with a new address
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h001;
    tick();
    check("hold_gnt1", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    m0_addr = 12'h002;
    tick();
    check("hold_ack1", {30'd0, m1_ack, m0_ack}, 32'd1);
    check("hold_rd1", {16'd0, m0_rdata}, 32'h00001111);
    tick();
    check("hold_gnt2", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    tick();
    check("hold_ack2", {30'd0, m1_ack, m0_ack}, 32'd1);
    check("hold_rd2", {16'd0, m0_rdata}, 32'h00002222);
    tick();
    check_quiet("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_arbiter
